// File: rtl/des_subkey_gen.sv
// -----------------------------------------------------------------------------
// des_subkey_gen
//   Iterative DES key schedule. Takes the 56-bit post-PC-1 key {C,D} and emits
//   the 16 48-bit round subkeys, one per valid/ready handshake.
//     decrypt_i = 0 : K1..K16, C and D left-rotated between subkeys
//     decrypt_i = 1 : K16..K1, C and D right-rotated between subkeys
//
// Ports
//   clk             clock, all state on posedge
//   rst             synchronous reset, active high
//   key_valid_i     key_i / decrypt_i valid
//   key_ready_o     block idle, can accept a key
//   key_i[55:0]     post-PC-1 key, C = key_i[55:28], D = key_i[27:0]
//   decrypt_i       subkey order select (sampled on accept only)
//   subkey_valid_o  subkey_o / round_o / last_o valid
//   subkey_ready_i  downstream accepts the current subkey
//   subkey_o[47:0]  PC-2 of the C||D register (combinational)
//   round_o[3:0]    emission index, 0 = first subkey of the key
//   last_o          high with the 16th subkey
// -----------------------------------------------------------------------------
module des_subkey_gen #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  input  logic [55:0] key_i,
  input  logic        decrypt_i,
  output logic        subkey_valid_o,
  input  logic        subkey_ready_i,
  output logic [47:0] subkey_o,
  output logic [3:0]  round_o,
  output logic        last_o
);

  // The shift tables and the 4-bit round counter only describe DES proper.
  if (ROUNDS != 16) begin : g_bad_rounds
    $error("des_subkey_gen: ROUNDS must be 16");
  end

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  // PC-2 selection, FIPS 46-3 numbering: entry n picks bit n of {C,D},
  // where bit 1 is the MSB. Entry 0 lands in subkey_o[47].
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  logic [0:0]  state;
  logic [55:0] cd;
  logic [3:0]  round;
  logic        dir;      // latched decrypt_i for the key in flight

  // Rotation applied when moving to emission index r.
  //   encrypt : left by 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1
  //   decrypt : right by 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1
  // The decrypt table is the encrypt table read backwards (shifted by one),
  // and its leading 0 works because the 28 total left shifts of the encrypt
  // schedule bring C and D back to the loaded value, so K16 = PC2(key_i).
  function automatic logic [1:0] rot_amt(input logic [3:0] r, input logic dec);
    logic [1:0] a;
    case (r)
      4'd0, 4'd1, 4'd8, 4'd15: a = 2'd1;
      default:                 a = 2'd2;
    endcase
    if (dec && (r == 4'd0)) a = 2'd0;
    return a;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n,
                                        input logic right);
    logic [27:0] y;
    case ({right, n})
      3'b001:  y = {x[26:0], x[27]};
      3'b010:  y = {x[25:0], x[27:26]};
      3'b101:  y = {x[0],    x[27:1]};
      3'b110:  y = {x[1:0],  x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

  // C and D halves rotate independently; bits never cross the midpoint.
  function automatic logic [55:0] rot56(input logic [55:0] x, input logic [1:0] n,
                                        input logic right);
    return {rot28(x[55:28], n, right), rot28(x[27:0], n, right)};
  endfunction

  logic [3:0] round_nxt;
  logic       hs;

  assign round_nxt = round + 4'd1;
  assign hs        = (state == EMIT) && subkey_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cd    <= '0;
      round <= '0;
      dir   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid_i) begin
            dir   <= decrypt_i;
            cd    <= rot56(key_i, rot_amt(4'd0, decrypt_i), decrypt_i);
            round <= '0;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (hs) begin
            if (round == LAST_ROUND) begin
              state <= IDLE;
              round <= '0;
            end else begin
              round <= round_nxt;
              cd    <= rot56(cd, rot_amt(round_nxt, dir), dir);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // PC-2 is pure wiring on the register, so subkey_o holds while stalled.
  always_comb begin
    subkey_o = '0;
    for (int i = 0; i < 48; i++) begin
      subkey_o[47 - i] = cd[56 - PC2_TAB[i]];
    end
  end

  assign key_ready_o    = (state == IDLE);
  assign subkey_valid_o = (state == EMIT);
  assign round_o        = round;
  assign last_o         = (state == EMIT) && (round == LAST_ROUND);

endmodule

// File: tb/tb_des_subkey_gen.sv
module tb_des_subkey_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid_i;
  logic        key_ready_o;
  logic [55:0] key_i;
  logic        decrypt_i;
  logic        subkey_valid_o;
  logic        subkey_ready_i;
  logic [47:0] subkey_o;
  logic [3:0]  round_o;
  logic        last_o;

  des_subkey_gen #(.ROUNDS(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid_i    (key_valid_i),
    .key_ready_o    (key_ready_o),
    .key_i          (key_i),
    .decrypt_i      (decrypt_i),
    .subkey_valid_o (subkey_valid_o),
    .subkey_ready_i (subkey_ready_i),
    .subkey_o       (subkey_o),
    .round_o        (round_o),
    .last_o         (last_o)
  );

  always #5 clk = ~clk;

  typedef logic [47:0] sched_t [16];

  localparam logic [55:0] FIPS_KEY = 56'hF0CCAAF556678F;
  localparam logic [47:0] FIPS_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] FIPS_K16 = 48'hCB3D8B0E17F5;

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Textbook schedule: cumulative left shifts C_i, D_i, K_i = PC2(C_i D_i);
  // decrypt order is simply the encrypt list reversed.
  function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
    logic [55:0] cd;
    logic [47:0] k;
    cd = {c, d};
    for (int j = 1; j <= 48; j++) k[48 - j] = cd[56 - PC2_T[j - 1]];
    return k;
  endfunction

  function automatic sched_t build_sched(input logic [55:0] key, input logic dec);
    sched_t e;
    sched_t r;
    logic [27:0] c, d;
    c = key[55:28];
    d = key[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < SHIFTS[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      e[i] = pc2(c, d);
    end
    for (int i = 0; i < 16; i++) r[i] = dec ? e[15 - i] : e[i];
    return r;
  endfunction

  // Model state: busy flag, emission index, expected list.
  logic   m_busy;
  int     m_idx;
  sched_t m_exp;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_idx  <= 0;
    end else if (!m_busy) begin
      if (key_valid_i) begin
        m_exp  <= build_sched(key_i, decrypt_i);
        m_busy <= 1'b1;
        m_idx  <= 0;
      end
    end else if (subkey_ready_i) begin
      if (m_idx == 15) begin
        m_busy <= 1'b0;
        m_idx  <= 0;
      end else begin
        m_idx <= m_idx + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (m_busy) begin
        check("cmp_valid",  64'(subkey_valid_o), 64'd1);
        check("cmp_ready",  64'(key_ready_o),    64'd0);
        check("cmp_subkey", 64'(subkey_o),       64'(m_exp[m_idx]));
        check("cmp_round",  64'(round_o),        64'(m_idx));
        check("cmp_last",   64'(last_o),         64'(m_idx == 15));
      end else begin
        check("cmp_idle_valid", 64'(subkey_valid_o), 64'd0);
        check("cmp_idle_ready", 64'(key_ready_o),    64'd1);
        check("cmp_idle_last",  64'(last_o),         64'd0);
      end
    end
  end

  task automatic send_key(input logic [55:0] k, input logic dec);
    int t;
    t = 0;
    while (!key_ready_o && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!key_ready_o) check("send_key_timeout", 64'(key_ready_o), 64'd1);
    key_valid_i = 1'b1;
    key_i       = k;
    decrypt_i   = dec;
    @(posedge clk); #1;
    key_valid_i = 1'b0;
    key_i       = {$urandom, $urandom};  // must not affect the sequence in flight
    decrypt_i   = ~dec;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!key_ready_o && t < 60) begin
      @(posedge clk); #1; t++;
    end
    check("wait_idle", 64'(key_ready_o), 64'd1);
  endtask

  // Ready held high: record 16 consecutive subkeys, then expect idle.
  task automatic run_seq(output sched_t seen, input string nm);
    int nv;
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      seen[i] = subkey_o;
      if (subkey_valid_o) nv++;
      if (i == 15) check({nm, "_last"}, 64'(last_o), 64'd1);
      @(posedge clk); #1;
    end
    check({nm, "_valid_cycles"}, 64'(nv), 64'd16);
    @(negedge clk);
    check({nm, "_done"}, 64'(subkey_valid_o), 64'd0);
  endtask

  sched_t enc_seen, dec_seen, bp_seen, tmp;
  bit     ok;
  int     hs, cyc;

  initial begin
    rst = 1'b1; key_valid_i = 1'b0; key_i = '0; decrypt_i = 1'b0; subkey_ready_i = 1'b1;

    // Model pinned against FIPS 46-3 literals.
    tmp = build_sched(FIPS_KEY, 1'b0);
    check("model_enc_k1",  64'(tmp[0]),  64'(FIPS_K1));
    check("model_enc_k16", 64'(tmp[15]), 64'(FIPS_K16));
    tmp = build_sched(FIPS_KEY, 1'b1);
    check("model_dec_first", 64'(tmp[0]), 64'(FIPS_K16));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  64'(key_ready_o),    64'd1);
    check("rst_valid",  64'(subkey_valid_o), 64'd0);
    check("rst_subkey", 64'(subkey_o),       64'd0);
    check("rst_round",  64'(round_o),        64'd0);
    check("rst_last",   64'(last_o),         64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Encrypt, FIPS vector
    send_key(FIPS_KEY, 1'b0);
    run_seq(enc_seen, "enc");
    check("enc_k1",  64'(enc_seen[0]),  64'(FIPS_K1));
    check("enc_k16", 64'(enc_seen[15]), 64'(FIPS_K16));

    // Decrypt, same key: exact reverse
    send_key(FIPS_KEY, 1'b1);
    run_seq(dec_seen, "dec");
    check("dec_first", 64'(dec_seen[0]),  64'(FIPS_K16));
    check("dec_last",  64'(dec_seen[15]), 64'(FIPS_K1));
    ok = 1'b1;
    for (int i = 0; i < 16; i++) if (dec_seen[i] !== enc_seen[15 - i]) ok = 1'b0;
    check("dec_reverse", 64'(ok), 64'd1);

    // Backpressure, ~40% ready
    send_key(FIPS_KEY, 1'b0);
    hs = 0; cyc = 0;
    while (hs < 16 && cyc < 400) begin
      subkey_ready_i = ($urandom_range(0, 99) < 40);
      @(negedge clk);
      if (subkey_valid_o && subkey_ready_i) begin
        bp_seen[hs] = subkey_o;
        hs++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    subkey_ready_i = 1'b1;
    check("bp_handshakes", 64'(hs), 64'd16);
    ok = 1'b1;
    for (int i = 0; i < 16; i++) if (bp_seen[i] !== enc_seen[i]) ok = 1'b0;
    check("bp_sequence", 64'(ok), 64'd1);
    @(negedge clk);
    check("bp_done", 64'(subkey_valid_o), 64'd0);

    // Key while busy is ignored; key right after the last handshake is taken.
    send_key(56'h13579BDF02468A, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    key_valid_i = 1'b1; key_i = 56'hABCDEF01234567; decrypt_i = 1'b1;
    @(posedge clk); #1;
    key_valid_i = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!last_o && cyc < 30) begin
      @(negedge clk); cyc++;
    end
    check("busy_last_seen", 64'(last_o), 64'd1);
    @(posedge clk); #1;
    key_valid_i = 1'b1; key_i = FIPS_KEY; decrypt_i = 1'b1;
    @(posedge clk); #1;
    key_valid_i = 1'b0;
    @(negedge clk);
    check("b2b_valid",  64'(subkey_valid_o), 64'd1);
    check("b2b_round",  64'(round_o),        64'd0);
    check("b2b_subkey", 64'(subkey_o),       64'(FIPS_K16));
    @(posedge clk); #1;
    wait_idle();

    // Corners: all-zero and all-one keys in both directions
    for (int c = 0; c < 4; c++) begin
      send_key((c < 2) ? 56'h0 : {56{1'b1}}, c[0]);
      ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (subkey_o !== ((c < 2) ? 48'h0 : {48{1'b1}})) ok = 1'b0;
        @(posedge clk); #1;
      end
      check($sformatf("corner_%0d", c), 64'(ok), 64'd1);
      wait_idle();
    end

    // Reset mid-EMIT at round 5
    send_key(FIPS_KEY, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_rst_round", 64'(round_o), 64'd5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_valid",  64'(subkey_valid_o), 64'd0);
    check("mid_rst_ready",  64'(key_ready_o),    64'd1);
    check("mid_rst_round",  64'(round_o),        64'd0);
    check("mid_rst_subkey", 64'(subkey_o),       64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_rst_idle", 64'(subkey_valid_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
